// File: rtl/ones_scan_pkg.sv
// rtl/ones_scan_pkg.sv - shared state encoding, default sizes and response record for the ones-scan scheduler
package ones_scan_pkg;

  localparam int DEF_WORD_SIZE    = 32;
  localparam int DEF_COUNTER_SIZE = 6;
  localparam int DEF_TIMEOUT      = 63;

  // Widest requester ID needed for up to 8 requesters.
  localparam int MAX_ID_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ARM,
    ST_RUN,
    ST_SETTLE_W,
    ST_RESP
  } sched_state_t;

  typedef struct packed {
    logic [MAX_ID_W-1:0]         id;
    logic [DEF_COUNTER_SIZE-1:0] count;
    logic                        err;
  } resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or above ptr, with wrap
//   req   in  N   request levels
//   ptr   in  IW  highest-priority position
//   grant out N   one-hot grant (all zero when req is zero)
//   id    out IW  encoded index of the granted request
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] id
);

  function automatic int wrap_idx(input int p, input int k);
    int s;
    s = p + k;
    return (s >= N) ? s - N : s;
  endfunction

  // Walk from the farthest position back towards ptr so the closest set bit wins.
  always_comb begin
    grant = '0;
    id    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[wrap_idx(int'(ptr), k)]) begin
        grant                          = '0;
        grant[wrap_idx(int'(ptr), k)]  = 1'b1;
        id                             = IW'(wrap_idx(int'(ptr), k));
      end
    end
  end

endmodule

// File: rtl/ones_scan_scheduler.sv
// rtl/ones_scan_scheduler.sv - shares one max-consecutive-ones engine between NUM_REQ requesters
//   clk, reset                   clock, synchronous active-high reset
//   req, req_data, ack           request levels, flattened words, one-cycle capture pulse
//   resp_valid/ready/id/count/err result handshake back to the host side
//   eng_start/data/busy/done/bit_count  engine interface
//   sched_busy                   high whenever a job or response is outstanding
module ones_scan_scheduler
  import ones_scan_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int WORD_SIZE    = DEF_WORD_SIZE,
  parameter int COUNTER_SIZE = DEF_COUNTER_SIZE,
  parameter int ID_W         = $clog2(NUM_REQ),
  parameter int SETTLE       = 2,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*WORD_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [ID_W-1:0]              resp_id,
  output logic [COUNTER_SIZE-1:0]      resp_count,
  output logic                         resp_err,
  output logic                         eng_start,
  output logic [WORD_SIZE-1:0]         eng_data,
  input  logic                         eng_busy,
  input  logic                         eng_done,
  input  logic [COUNTER_SIZE-1:0]      eng_bit_count,
  output logic                         sched_busy
);

  // One timer serves the ARM/RUN watchdog and the settle delay; sized for either.
  localparam int TW = $clog2(TIMEOUT + 4);

  sched_state_t             state_q, state_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [ID_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]          id_q, id_d;
  logic [WORD_SIZE-1:0]     job_data_q, job_data_d;
  logic [NUM_REQ-1:0]       ack_q, ack_d;
  logic                     eng_start_q, eng_start_d;
  logic [COUNTER_SIZE-1:0]  resp_count_q, resp_count_d;
  logic                     resp_err_q, resp_err_d;

  logic [NUM_REQ-1:0]       gnt;
  logic [ID_W-1:0]          gnt_id;
  logic [WORD_SIZE-1:0]     gnt_word;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr_q),
    .grant (gnt),
    .id    (gnt_id)
  );

  // Word mux driven by the one-hot grant keeps every slice index constant.
  always_comb begin
    gnt_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_word = gnt_word | req_data[i*WORD_SIZE +: WORD_SIZE];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      job_data_q   <= '0;
      ack_q        <= '0;
      eng_start_q  <= 1'b0;
      resp_count_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      job_data_q   <= job_data_d;
      ack_q        <= ack_d;
      eng_start_q  <= eng_start_d;
      resp_count_q <= resp_count_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    job_data_d   = job_data_q;
    ack_d        = '0;
    eng_start_d  = 1'b0;
    resp_count_d = resp_count_q;
    resp_err_d   = resp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        // ack and eng_start are registered, so both show up in the ISSUE cycle.
        if (|req) begin
          id_d        = gnt_id;
          job_data_d  = gnt_word;
          ack_d       = gnt;
          eng_start_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_ARM;
      end

      // eng_done may still be high from the previous job, so only busy counts here.
      ST_ARM: begin
        if (eng_busy) begin
          timer_d = '0;
          state_d = ST_RUN;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          resp_count_d = '0;
          resp_err_d   = 1'b1;
          state_d      = ST_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_RUN: begin
        if (!eng_busy && eng_done) begin
          timer_d = '0;
          state_d = ST_SETTLE_W;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          resp_count_d = '0;
          resp_err_d   = 1'b1;
          state_d      = ST_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_SETTLE_W: begin
        if (timer_q == TW'(SETTLE - 1)) begin
          resp_count_d = eng_bit_count;
          resp_err_d   = 1'b0;
          state_d      = ST_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_RESP: begin
        // Pointer only moves on a delivered response, which is what bounds the wait.
        if (resp_ready) begin
          rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign ack        = ack_q;
  assign eng_start  = eng_start_q;
  assign eng_data   = job_data_q;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_id    = id_q;
  assign resp_count = resp_count_q;
  assign resp_err   = resp_err_q;
  assign sched_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ones_scan_scheduler.sv
// tb/tb_ones_scan_scheduler.sv - directed self-checking bench for ones_scan_scheduler with a behavioural engine
module tb_ones_scan_scheduler;
  import ones_scan_pkg::*;

  localparam int NUM_REQ      = 4;
  localparam int WORD_SIZE    = 32;
  localparam int COUNTER_SIZE = 6;
  localparam int ID_W         = 2;
  localparam int TIMEOUT      = 63;

  logic                         clk = 1'b0;
  logic                         reset;
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*WORD_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           ack;
  logic                         resp_valid;
  logic                         resp_ready;
  logic [ID_W-1:0]              resp_id;
  logic [COUNTER_SIZE-1:0]      resp_count;
  logic                         resp_err;
  logic                         eng_start;
  logic [WORD_SIZE-1:0]         eng_data;
  logic                         eng_busy;
  logic                         eng_done;
  logic [COUNTER_SIZE-1:0]      eng_bit_count;
  logic                         sched_busy;

  int errors = 0;
  int checks = 0;

  typedef enum int {ENG_NORMAL, ENG_STALE, ENG_NO_BUSY, ENG_STUCK} eng_mode_t;
  eng_mode_t eng_mode   = ENG_NORMAL;
  int        busy_delay = 1;
  int        busy_len   = 3;

  ones_scan_scheduler #(
    .NUM_REQ      (NUM_REQ),
    .WORD_SIZE    (WORD_SIZE),
    .COUNTER_SIZE (COUNTER_SIZE),
    .ID_W         (ID_W),
    .SETTLE       (2),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_data      (req_data),
    .ack           (ack),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_count    (resp_count),
    .resp_err      (resp_err),
    .eng_start     (eng_start),
    .eng_data      (eng_data),
    .eng_busy      (eng_busy),
    .eng_done      (eng_done),
    .eng_bit_count (eng_bit_count),
    .sched_busy    (sched_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] max_run(input logic [31:0] w);
    int best = 0;
    int cur  = 0;
    for (int i = 0; i < 32; i++) begin
      if (w[i]) begin
        cur++;
        if (cur > best) best = cur;
      end else begin
        cur = 0;
      end
    end
    return 6'(best);
  endfunction

  // Behavioural engine: busy rises busy_delay cycles after start, lasts busy_len cycles,
  // then done (level) with the result. Stale mode keeps the previous done until busy rises.
  initial begin : engine
    int           k;
    bit           running;
    logic [31:0]  lat_word;
    eng_busy      = 1'b0;
    eng_done      = 1'b0;
    eng_bit_count = '0;
    running       = 1'b0;
    k             = 0;
    lat_word      = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        eng_busy      = 1'b0;
        eng_done      = 1'b0;
        eng_bit_count = '0;
        running       = 1'b0;
      end else if (eng_start) begin
        lat_word = eng_data;
        k        = 0;
        running  = 1'b1;
        eng_busy = 1'b0;
        if (eng_mode != ENG_STALE) eng_done = 1'b0;
      end else if (running) begin
        k++;
        if (k == busy_delay && eng_mode != ENG_NO_BUSY) begin
          eng_busy = 1'b1;
          eng_done = 1'b0;
        end
        if (k == busy_delay + busy_len && eng_mode != ENG_NO_BUSY && eng_mode != ENG_STUCK) begin
          eng_busy      = 1'b0;
          eng_done      = 1'b1;
          eng_bit_count = max_run(lat_word);
          running       = 1'b0;
        end
      end
    end
  end

  task automatic set_word(input int i, input logic [31:0] w);
    req_data[i*WORD_SIZE +: WORD_SIZE] = w;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ack"},        32'(ack),        32'h0);
    check({tag, "_eng_start"},  32'(eng_start),  32'h0);
    check({tag, "_eng_data"},   eng_data,        32'h0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
    check({tag, "_resp_id"},    32'(resp_id),    32'h0);
    check({tag, "_resp_count"}, 32'(resp_count), 32'h0);
    check({tag, "_resp_err"},   32'(resp_err),   32'h0);
    check({tag, "_sched_busy"}, 32'(sched_busy), 32'h0);
  endtask

  // Returns at the negedge of the ack cycle; n = cycles waited.
  task automatic wait_ack(input string tag, input logic [3:0] exp_ack, input logic [31:0] exp_data,
                          output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == '0 && n < 100);
    check({tag, "_ack"},       32'(ack),       32'(exp_ack));
    check({tag, "_eng_start"}, 32'(eng_start), 32'h1);
    check({tag, "_eng_data"},  eng_data,       exp_data);
  endtask

  // Latency counted in cycles from the ack cycle to the first resp_valid cycle.
  task automatic wait_resp(input string tag, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check({tag, "_ack_pulse"},   32'(ack),       32'h0);
        check({tag, "_start_pulse"}, 32'(eng_start), 32'h0);
      end
    end while (!resp_valid && lat < 200);
  endtask

  task automatic check_resp(input string tag, input resp_t e, input int lat, input int exp_lat);
    check({tag, "_valid"}, 32'(resp_valid), 32'h1);
    check({tag, "_id"},    32'(resp_id),    32'(e.id));
    check({tag, "_count"}, 32'(resp_count), 32'(e.count));
    check({tag, "_err"},   32'(resp_err),   32'(e.err));
    check({tag, "_lat"},   32'(lat),        32'(exp_lat));
  endtask

  // Leaves the bench at the negedge of the idle cycle that follows acceptance.
  task automatic accept(input string tag);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_drop"},     32'(resp_valid), 32'h0);
    check({tag, "_idle_ack"}, 32'(ack),        32'h0);
  endtask

  resp_t       exp_tab [5];
  logic [31:0] cw      [4];

  initial begin : main
    int n;
    int lat;
    int bad;
    reset      = 1'b1;
    req        = '0;
    req_data   = '0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks("reset");
    reset = 1'b0;

    // Contention: all four held, runs 1..4, rr_ptr starts at 0.
    cw[0] = 32'h0000_0005;
    cw[1] = 32'h0000_0036;
    cw[2] = 32'h0000_00E7;
    cw[3] = 32'h000F_0F0F;
    exp_tab[0] = '{id: 3'd0, count: 6'd1, err: 1'b0};
    exp_tab[1] = '{id: 3'd1, count: 6'd2, err: 1'b0};
    exp_tab[2] = '{id: 3'd2, count: 6'd3, err: 1'b0};
    exp_tab[3] = '{id: 3'd3, count: 6'd4, err: 1'b0};
    exp_tab[4] = '{id: 3'd0, count: 6'd1, err: 1'b0};
    for (int i = 0; i < 4; i++) set_word(i, cw[i]);
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_ack("cont", 4'(1 << exp_tab[j].id), cw[exp_tab[j].id], n);
      if (j > 0) check("cont_gap", 32'(n), 32'd1);
      if (j == 4) req = '0;
      wait_resp("cont", lat);
      check_resp("cont", exp_tab[j], lat, 7);
      accept("cont");
    end

    // Single job on requester 1.
    set_word(1, 32'h0000_0F70);
    req = 4'b0010;
    wait_ack("single", 4'b0010, 32'h0000_0F70, n);
    req = '0;
    wait_resp("single", lat);
    check_resp("single", '{id: 3'd1, count: 6'd4, err: 1'b0}, lat, 7);
    accept("single");

    // Backpressure: requester 0 waits behind an unaccepted response.
    set_word(2, 32'hFFFF_0000);
    req = 4'b0100;
    wait_ack("bp", 4'b0100, 32'hFFFF_0000, n);
    set_word(0, 32'h0000_0007);
    req = 4'b0001;
    wait_resp("bp", lat);
    check_resp("bp", '{id: 3'd2, count: 6'd16, err: 1'b0}, lat, 7);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_count !== 6'd16 ||
          resp_err !== 1'b0 || ack !== '0 || eng_start !== 1'b0) bad++;
    end
    check("bp_hold", 32'(bad), 32'd0);
    accept("bp");
    wait_ack("bp_next", 4'b0001, 32'h0000_0007, n);
    check("bp_gap", 32'(n), 32'd1);
    req = '0;
    wait_resp("bp_next", lat);
    check_resp("bp_next", '{id: 3'd0, count: 6'd3, err: 1'b0}, lat, 7);
    accept("bp_next");

    // Stale done from the previous job with an old count of 3 on the bus.
    eng_mode   = ENG_STALE;
    busy_delay = 2;
    busy_len   = 2;
    set_word(3, 32'hFFFF_FFFF);
    req = 4'b1000;
    wait_ack("stale", 4'b1000, 32'hFFFF_FFFF, n);
    req = '0;
    wait_resp("stale", lat);
    check_resp("stale", '{id: 3'd3, count: 6'd32, err: 1'b0}, lat, 7);
    accept("stale");

    // Engine never goes busy: ARM watchdog.
    eng_mode   = ENG_NO_BUSY;
    busy_delay = 1;
    set_word(0, 32'h0000_00FF);
    req = 4'b0001;
    wait_ack("nobusy", 4'b0001, 32'h0000_00FF, n);
    req = '0;
    wait_resp("nobusy", lat);
    check_resp("nobusy", '{id: 3'd0, count: 6'd0, err: 1'b1}, lat, TIMEOUT + 1);
    accept("nobusy");

    // Engine stuck busy: RUN watchdog.
    eng_mode = ENG_STUCK;
    set_word(1, 32'h0000_0001);
    req = 4'b0010;
    wait_ack("stuck", 4'b0010, 32'h0000_0001, n);
    req = '0;
    wait_resp("stuck", lat);
    check_resp("stuck", '{id: 3'd1, count: 6'd0, err: 1'b1}, lat, TIMEOUT + 2);
    accept("stuck");

    // Recovery after the hangs.
    eng_mode = ENG_NORMAL;
    busy_len = 3;
    set_word(2, 32'h00FF_0000);
    req = 4'b0100;
    wait_ack("recover", 4'b0100, 32'h00FF_0000, n);
    req = '0;
    wait_resp("recover", lat);
    check_resp("recover", '{id: 3'd2, count: 6'd8, err: 1'b0}, lat, 7);
    accept("recover");

    // Reset in the middle of RUN; rr_ptr is 3 beforehand.
    busy_len = 20;
    set_word(3, 32'h0000_000F);
    req = 4'b1000;
    wait_ack("midrst", 4'b1000, 32'h0000_000F, n);
    req = '0;
    repeat (5) @(negedge clk);
    check("midrst_busy", 32'(sched_busy), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset_checks("midrst");
    reset    = 1'b0;
    busy_len = 3;
    set_word(1, 32'h0000_0003);
    set_word(3, 32'h0000_00F0);
    req = 4'b1010;
    wait_ack("postrst", 4'b0010, 32'h0000_0003, n);
    req = '0;
    wait_resp("postrst", lat);
    check_resp("postrst", '{id: 3'd1, count: 6'd2, err: 1'b0}, lat, 7);
    accept("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ones_scan_scheduler.md
Name: ones_scan_scheduler

Overview:
- Shares one max-consecutive-ones engine between NUM_REQ requesters. The engine has a start/data/busy/done/bit_count interface, and one job runs at a time.
- Round-robin arbitration chooses a requester. The block latches that requester's word, pulses eng_start with eng_data valid in the same cycle, and tracks the engine through busy and then done.
- It returns the result with the requester ID over a valid/ready response port.
- A watchdog flags engine hangs. The block sits between the host-side request fabric and the engine instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WORD_SIZE, 32, width of each request word.
- COUNTER_SIZE, 6, width of the result, matching the engine's bit_count.
- ID_W, $clog2(NUM_REQ), width of the requester ID.
- SETTLE, 2, cycles waited after done is first seen before eng_bit_count is sampled (1..3).
- TIMEOUT, 63, maximum RUN cycles before an abort with error.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester request level; held until ack
- req_data  in  NUM_REQ*WORD_SIZE  flattened words; requester i occupies bits [i*WORD_SIZE +: WORD_SIZE]
- ack  out  NUM_REQ  one-hot, 1-cycle pulse when that requester's word is captured
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts the response
- resp_id  out  ID_W  requester that owns the response
- resp_count  out  COUNTER_SIZE  max run of ones
- resp_err  out  1  job aborted by timeout; resp_count forced to 0
- eng_start  out  1  start pulse to the engine
- eng_data  out  WORD_SIZE  word to the engine, valid while eng_start=1
- eng_busy  in  1  engine counting
- eng_done  in  1  engine finished (level, stays high until the next start)
- eng_bit_count  in  COUNTER_SIZE  engine result
- sched_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, active-high, clk): state=IDLE, rr_ptr=0, ack=0, eng_start=0, eng_data=0, resp_valid=0, resp_id=0, resp_count=0, resp_err=0, timers=0.
- Reset asserted mid-job drops the job silently; no ack is re-issued. The engine is reset by the same reset.
- States: IDLE, ISSUE, ARM, RUN, SETTLE_W, RESP.
- IDLE:
  - If req!=0, pick the first set bit searching from rr_ptr upward, with wrap.
  - Register the ID, latch its word into job_data, pulse ack[id] for 1 cycle, go to ISSUE.
  - A requester may drop req the cycle after ack.
- ISSUE (1 cycle): eng_start=1, eng_data=job_data; go to ARM.
- ARM: eng_done is ignored because it may still be high from the previous job.
  - eng_busy=1: go to RUN.
  - eng_busy=0 for TIMEOUT cycles: abort.
- RUN:
  - Counts the cycles spent in RUN.
  - eng_busy=0 and eng_done=1: go to SETTLE_W.
  - Count reaches TIMEOUT: abort.
- SETTLE_W: wait SETTLE cycles, then sample eng_bit_count into resp_count, set resp_err=0, go to RESP.
- Abort (from ARM or RUN): resp_count=0, resp_err=1, go to RESP.
- RESP:
  - resp_valid=1; resp_id, resp_count and resp_err are held stable.
  - On resp_valid&&resp_ready: drop resp_valid, set rr_ptr=(id+1) mod NUM_REQ, go to IDLE.
  - Backpressure is unbounded.
- Throughput:
  - No new grant is made while a job or response is outstanding, so at most one job is in flight.
  - Minimum back-to-back spacing is 1 idle cycle between resp accept and the next ack.
- Fairness: rr_ptr advances only on a completed response. Any requester holding req is served within NUM_REQ jobs.
- Latency from ack to resp_valid = 1 (ISSUE) + ARM + RUN + SETTLE + 1.
- Simultaneous events:
  - Multiple req bits: round-robin picks one.
  - req asserted during RESP is not granted until IDLE.
- eng_data holds job_data from ISSUE until the next grant; the engine reads it only during start.

Decomposition:
- Shared package ones_scan_pkg holds:
  - the state enum;
  - the default constants WORD_SIZE=32, COUNTER_SIZE=6, TIMEOUT=63;
  - a resp struct {id, count, err}.
- One natural sub-module is rr_arbiter (parameter N). Inputs are req and ptr; outputs are a one-hot grant and an encoded ID, combinational.
- The top holds the FSM, job register, timers and response register.

Test Plan:
- Single job: req[1]=1, word 0x0000_0F70 -> ack[1] one pulse; eng_start exactly 1 cycle with eng_data=0x0000_0F70; resp_valid with id=1, count=4, err=0.
- Contention: req=4'b1111 held, words with runs 1,2,3,4 -> grant order 0,1,2,3,0; each resp_id matches its count.
- Backpressure: resp_ready=0 for 20 cycles -> resp fields stable, no ack issued, eng_start=0; accept -> next grant after 1 idle cycle.
- Stale done: engine model leaves eng_done=1 from the prior job, and the new job's busy arrives 1 cycle after start -> no early capture; count belongs to the new word (0xFFFF_FFFF -> 32).
- Hang: engine model never asserts busy, or holds busy forever -> resp after TIMEOUT cycles with err=1, count=0; the next job proceeds normally.
- Reset during RUN -> all outputs return to their reset values the next cycle, no resp issued; rr_ptr=0, so req=4'b1010 grants 1.
